hpi_bus_master: RTL

Hardware HPI master for the on-board USB host controller. It replaces the current software-driven PIO toggling of the cs/r/w/address/data lines with a command-driven sequencer. The Nios-side logic issues a single command (read or write, HPI register, beat count). The block generates timed chip-select, strobe and data-bus phases for each beat, including multi-beat bursts on the auto-incrementing HPI DATA register. It sits between the Avalon/PIO glue and the top-level OTG pins.

---
 rtl/hpi_pkg.sv | 29 ++
 rtl/hpi_bus_master_if.sv | 39 +++
 rtl/hpi_phase_timer.sv | 28 ++
 rtl/hpi_bus_master.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/hpi_pkg.sv
// Shared types and constants for the HPI bus master: sequencer states,
// HPI register map, and phase-counter sizing.
package hpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_WD,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } state_t;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  // Counter holds (phase length - 1), so clog2 of the longest phase suffices.
  function automatic int phase_cnt_w(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/hpi_bus_master_if.sv
// Command, write/read data and HPI pad signals of the bus master.
// master = sequencer side, slave = Nios glue plus pads.
interface hpi_bus_master_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2,
  parameter int LEN_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;
  logic              hpi_cs_n;
  logic              hpi_r_n;
  logic              hpi_w_n;
  logic [ADDR_W-1:0] hpi_addr;
  logic [DATA_W-1:0] hpi_data_out;
  logic              hpi_data_oe;
  logic [DATA_W-1:0] hpi_data_in;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, hpi_data_in,
    output cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
           hpi_cs_n, hpi_r_n, hpi_w_n, hpi_addr, hpi_data_out, hpi_data_oe
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, hpi_data_in,
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
           hpi_cs_n, hpi_r_n, hpi_w_n, hpi_addr, hpi_data_out, hpi_data_oe
  );
endinterface

// File: rtl/hpi_phase_timer.sv
// Loadable down-counter timing one bus phase; last is high on the phase's final cycle.
// Latency: load_val = N-1 gives last on the Nth cycle after the load edge.
// Backpressure: none; free-running until reloaded, parks at zero.
module hpi_phase_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/hpi_bus_master.sv
// Command-driven HPI sequencer: SETUP/STROBE/HOLD/RECOVER per beat, bursts on one address.
// Latency (defaults): single read done 15 cycles after accept, single write 16 with data ready.
// Backpressure: cmd_ready only in IDLE; stalls in WAIT_WD for write data; rd_valid unthrottled.
module hpi_bus_master
  import hpi_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 2,
  parameter int LEN_W       = 8,
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 4,
  parameter int HOLD_CYC    = 2,
  parameter int RECOVER_CYC = 6
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  hpi_bus_master_if.master bus
);

  localparam int CNT_W = phase_cnt_w(SETUP_CYC, STROBE_CYC, HOLD_CYC, RECOVER_CYC);

  state_t            state, state_nxt;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_last;

  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [LEN_W-1:0]  beats_left;
  logic [DATA_W-1:0] data_out_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              done_q;

  logic accept, wd_take, rd_sample, beat_end, finish;

  assign accept    = (state == ST_IDLE) && bus.cmd_valid;
  assign wd_take   = (state == ST_WAIT_WD) && bus.wr_valid;
  assign rd_sample = (state == ST_STROBE) && tmr_last && !lat_write;
  assign beat_end  = (state == ST_RECOVER) && tmr_last;
  assign finish    = beat_end && (beats_left == '0);

  hpi_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .last     (tmr_last)
  );

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) state <= ST_IDLE;
    else                state <= state_nxt;
  end

  // Every transition enters a fresh phase, so the timer reloads on any state change.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (bus.cmd_valid) state_nxt = bus.cmd_write ? ST_WAIT_WD : ST_SETUP;
      ST_WAIT_WD: if (bus.wr_valid)  state_nxt = ST_SETUP;
      ST_SETUP:   if (tmr_last)      state_nxt = ST_STROBE;
      ST_STROBE:  if (tmr_last)      state_nxt = ST_HOLD;
      ST_HOLD:    if (tmr_last)      state_nxt = ST_RECOVER;
      ST_RECOVER: if (tmr_last) begin
        if (beats_left == '0) state_nxt = ST_IDLE;
        else                  state_nxt = lat_write ? ST_WAIT_WD : ST_SETUP;
      end
      default:                       state_nxt = ST_IDLE;
    endcase

    tmr_load = (state_nxt != state);
    tmr_val  = '0;
    case (state_nxt)
      ST_SETUP:   tmr_val = CNT_W'(SETUP_CYC - 1);
      ST_STROBE:  tmr_val = CNT_W'(STROBE_CYC - 1);
      ST_HOLD:    tmr_val = CNT_W'(HOLD_CYC - 1);
      ST_RECOVER: tmr_val = CNT_W'(RECOVER_CYC - 1);
      default:    tmr_val = '0;
    endcase
  end

  always_comb begin
    bus.cmd_ready   = 1'b0;
    bus.wr_ready    = 1'b0;
    bus.busy        = 1'b1;
    bus.hpi_cs_n    = 1'b1;
    bus.hpi_r_n     = 1'b1;
    bus.hpi_w_n     = 1'b1;
    bus.hpi_data_oe = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
      end
      ST_WAIT_WD: bus.wr_ready = 1'b1;
      ST_SETUP, ST_HOLD: begin
        bus.hpi_cs_n    = 1'b0;
        bus.hpi_data_oe = lat_write;
      end
      ST_STROBE: begin
        bus.hpi_cs_n    = 1'b0;
        bus.hpi_data_oe = lat_write;
        bus.hpi_r_n     = lat_write;
        bus.hpi_w_n     = !lat_write;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      beats_left <= '0;
      data_out_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_valid_q <= rd_sample;
      done_q     <= finish;
      if (rd_sample) rd_data_q  <= bus.hpi_data_in;
      if (wd_take)   data_out_q <= bus.wr_data;
      if (accept) begin
        lat_write  <= bus.cmd_write;
        lat_addr   <= bus.cmd_addr;
        beats_left <= bus.cmd_len;
      end else if (beat_end && (beats_left != '0)) begin
        beats_left <= beats_left - LEN_W'(1);
      end
    end
  end

  assign bus.hpi_addr     = lat_addr;
  assign bus.hpi_data_out = data_out_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.done         = done_q;

endmodule
